ram_bist: RTL and testbench

RAM_BIST -- requirements
Module: ram_bist

---
 rtl/ram_pkg.sv | 22 ++
 rtl/ram_bist.sv | 141 ++++++++++++++
 tb/tb_ram_bist.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared RAM geometry, background pattern and march-test FSM state encoding.
// Used by the BIST controller and by any RAM model it drives.
package ram_pkg;

    localparam int          DATA_W = 8;
    localparam int          ADR_W  = 3;
    localparam int          SIZE   = 8;
    localparam logic [7:0]  PAT    = 8'h55;

    typedef enum logic [3:0] {
        IDLE,
        W0,
        R0W1_RD,
        R0W1_WR,
        R1W0_RD,
        R1W0_WR,
        R0_RD,
        R0_CHK,
        DONE
    } state_t;

endpackage

// File: rtl/ram_bist.sv
// March BIST initiator for a synchronous single-port RAM: 56 busy cycles per healthy run.
// No backpressure: the RAM must accept one access per cycle and return read data the next cycle.
module ram_bist
    import ram_pkg::*;
#(
    parameter int                data_w = DATA_W,
    parameter int                adr_w  = ADR_W,
    parameter int                size   = SIZE,
    parameter logic [data_w-1:0] pat    = PAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              w,
    output logic [adr_w-1:0]  data_adr,
    output logic [data_w-1:0] data_in,
    input  logic [data_w-1:0] data_out,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [adr_w-1:0]  fail_adr,
    output logic [data_w-1:0] fail_data
);

    localparam logic [adr_w-1:0] last_adr = adr_w'(size - 1);

    state_t            state;
    logic              chk;
    logic              mismatch;
    logic [data_w-1:0] exp_dat;

    // Read data arrives in the cycle after the RD access, so it is judged at the end of WR/CHK.
    always_comb begin
        exp_dat  = (state == R1W0_WR) ? ~pat : pat;
        chk      = (state == R0W1_WR) || (state == R1W0_WR) || (state == R0_CHK);
        mismatch = chk && (data_out != exp_dat);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            w         <= 1'b0;
            data_adr  <= '0;
            data_in   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_adr  <= '0;
            fail_data <= '0;
        end else if (mismatch) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            fail      <= 1'b1;
            fail_adr  <= data_adr;
            fail_data <= data_out;
            w         <= 1'b0;
            data_adr  <= '0;
            data_in   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= W0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        fail      <= 1'b0;
                        fail_adr  <= '0;
                        fail_data <= '0;
                        w         <= 1'b1;
                        data_adr  <= '0;
                        data_in   <= pat;
                    end
                end
                W0: begin
                    if (data_adr == last_adr) begin
                        state    <= R0W1_RD;
                        w        <= 1'b0;
                        data_adr <= '0;
                        data_in  <= '0;
                    end else begin
                        data_adr <= data_adr + 1'b1;
                    end
                end
                R0W1_RD: begin
                    state   <= R0W1_WR;
                    w       <= 1'b1;
                    data_in <= ~pat;
                end
                R0W1_WR: begin
                    w       <= 1'b0;
                    data_in <= '0;
                    if (data_adr == last_adr) begin
                        state <= R1W0_RD;
                    end else begin
                        state    <= R0W1_RD;
                        data_adr <= data_adr + 1'b1;
                    end
                end
                R1W0_RD: begin
                    state   <= R1W0_WR;
                    w       <= 1'b1;
                    data_in <= pat;
                end
                R1W0_WR: begin
                    w       <= 1'b0;
                    data_in <= '0;
                    if (data_adr == '0) begin
                        state <= R0_RD;
                    end else begin
                        state    <= R1W0_RD;
                        data_adr <= data_adr - 1'b1;
                    end
                end
                R0_RD: begin
                    state <= R0_CHK;
                end
                R0_CHK: begin
                    if (data_adr == last_adr) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        data_adr <= '0;
                    end else begin
                        state    <= R0_RD;
                        data_adr <= data_adr + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    w        <= 1'b0;
                    data_adr <= '0;
                    data_in  <= '0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist: behavioural RAM with injectable faults, scoreboard of expected RAM port ops.
module tb_ram_bist;
    import ram_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       w;
    logic [2:0] data_adr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       busy;
    logic       done;
    logic       fail;
    logic [2:0] fail_adr;
    logic [7:0] fail_data;

    int vectors = 0;
    int errors  = 0;
    int fault_mode = 0;  // 0 healthy, 1 bit1 stuck-at-0 at addr 5, 2 address bit2 ignored

    typedef struct packed {
        logic       w;
        logic [2:0] adr;
        logic [7:0] din;
    } op_t;

    op_t exp_q[$];
    logic [7:0] mem [8];

    always #5 clk = ~clk;

    ram_bist dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .w         (w),
        .data_adr  (data_adr),
        .data_in   (data_in),
        .data_out  (data_out),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_adr  (fail_adr),
        .fail_data (fail_data)
    );

    always @(posedge clk) begin
        logic [2:0] pa;
        pa = (fault_mode == 2) ? {1'b0, data_adr[1:0]} : data_adr;
        if (w) begin
            if (fault_mode == 1 && pa == 3'd5)
                mem[pa] <= data_in & 8'hFD;
            else
                mem[pa] <= data_in;
        end else begin
            data_out <= mem[pa];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent march sequence: W0 up, R0W1 up, R1W0 down, R0 up (reads carry din=0).
    task automatic push_march();
        for (int a = 0; a < 8; a++) exp_q.push_back({1'b1, 3'(a), 8'h55});
        for (int a = 0; a < 8; a++) begin
            exp_q.push_back({1'b0, 3'(a), 8'h00});
            exp_q.push_back({1'b1, 3'(a), 8'hAA});
        end
        for (int a = 7; a >= 0; a--) begin
            exp_q.push_back({1'b0, 3'(a), 8'h00});
            exp_q.push_back({1'b1, 3'(a), 8'h55});
        end
        for (int a = 0; a < 8; a++) begin
            exp_q.push_back({1'b0, 3'(a), 8'h00});
            exp_q.push_back({1'b0, 3'(a), 8'h00});
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {6'd0, w, data_adr, data_in, busy, done, fail, fail_adr, fail_data}, 32'd0);
    endtask

    task automatic run_and_check(input string tag, input int exp_cyc, input logic exp_fail,
                                 input logic [2:0] exp_fadr, input logic [7:0] exp_fdat,
                                 input int pulse_at);
        int  cyc;
        op_t e;
        logic more;
        exp_q.delete();
        push_march();
        @(negedge clk);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 200) begin
            more = (exp_q.size() > 0);
            e = more ? exp_q.pop_front() : '0;
            check({tag, "_port"},
                  {17'd0, busy, done, fail, w, data_adr, (w ? data_in : 8'h00)},
                  {17'd0, more, 1'b0, 1'b0, e.w, e.adr, e.din});
            start = (cyc == pulse_at);
            tick();
            cyc++;
        end
        start = 1'b0;
        check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_status"}, {29'd0, busy, done, fail}, {29'd0, 1'b0, 1'b1, exp_fail});
        check({tag, "_fail_adr"}, {29'd0, fail_adr}, {29'd0, exp_fadr});
        check({tag, "_fail_data"}, {24'd0, fail_data}, {24'd0, exp_fdat});
        check({tag, "_idle_port"}, {20'd0, w, data_adr, data_in}, 32'd0);
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        #1 rst = 1'b1;
        #2;
        check_all_zero("reset_state");
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        check_all_zero("idle_after_reset");

        run_and_check("healthy", 57, 1'b0, 3'd0, 8'h00, 0);
        run_and_check("start_ignored", 57, 1'b0, 3'd0, 8'h00, 10);

        fault_mode = 1;
        run_and_check("stuck_bit1", 31, 1'b1, 3'd5, 8'hA8, 0);
        fault_mode = 0;
        run_and_check("rerun_after_fail", 57, 1'b0, 3'd0, 8'h00, 0);

        fault_mode = 2;
        run_and_check("alias_bit2", 19, 1'b1, 3'd4, 8'hAA, 0);
        fault_mode = 0;

        // Start held high in DONE restarts, and stays ignored once busy.
        @(negedge clk);
        start = 1'b1;
        tick();
        check("held_restart", {20'd0, busy, done, w, data_adr, 1'b0}, {20'd0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0});
        tick();
        tick();
        tick();
        check("held_ignored", {26'd0, busy, w, data_adr, 1'b0}, {26'd0, 1'b1, 1'b1, 3'd3, 1'b0});
        start = 1'b0;
        for (int i = 4; i < 20; i++) tick();
        check("midrun_busy", {31'd0, busy}, 32'd1);
        #3 rst = 1'b1;
        #1;
        check_all_zero("async_reset_midrun");
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_all_zero("idle_after_midrun_reset");
        run_and_check("after_reset", 57, 1'b0, 3'd0, 8'h00, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
